// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the writeback stage and a
// small FIFO of late results, with starvation relief and a halt drain sequence.
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_wr_en,
    input  logic [2:0]               pipe_wr_reg,
    input  logic [15:0]              pipe_wr_data,
    input  logic                     pipe_halt,
    input  logic                     late_valid,
    input  logic [2:0]               late_reg,
    input  logic [15:0]              late_data,
    output logic                     late_ready,
    output logic                     stall_wb,
    output logic                     rf_wr_en,
    output logic [2:0]               rf_wr_reg,
    output logic [15:0]              rf_wr_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     halt_done
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} arbState_t;

    arbState_t                 stateReg;
    logic [DEPTH-1:0][2:0]     entryDst;
    logic [DEPTH-1:0][15:0]    entryData;
    logic [DEPTH-1:0]          entryLive;
    logic [DEPTH-1:0]          liveNext;
    logic [PTR_W-1:0]          rdPtrReg;
    logic [PTR_W-1:0]          wrPtrReg;
    logic [CNT_W-1:0]          countReg;
    logic [CNT_W-1:0]          countNext;
    logic [STARVE_W-1:0]       starveReg;

    logic [DEPTH-1:0]            slotOcc;
    logic [DEPTH-1:0]            slotLive;
    logic [DEPTH-1:0]            pipeHit;
    logic [DEPTH-1:0][PTR_W-1:0] slotIdx;

    logic [CNT_W-1:0] skipCnt;
    logic [CNT_W-1:0] popCnt;
    logic [PTR_W-1:0] headIdx;
    logic             liveFound;
    logic             inRun;
    logic             inDrain;
    logic             forceGrant;
    logic             pipeGrant;
    logic             fifoGrant;
    logic             pushFire;
    logic             pushKeep;
    logic             haltGo;
    logic             drainDone;

    // Slot gi is the gi-th oldest occupied entry; pipeHit is indexed physically.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gSlot
            assign slotIdx[gi]  = rdPtrReg + PTR_W'(gi);
            assign slotOcc[gi]  = (CNT_W'(gi) < countReg);
            assign slotLive[gi] = slotOcc[gi] && entryLive[slotIdx[gi]];
            assign pipeHit[gi]  = (entryDst[gi] == pipe_wr_reg);
        end
    endgenerate

    // Superseded entries ahead of the first live one are dropped in the same cycle,
    // so they never cost a grant slot.
    always_comb begin
        skipCnt   = '0;
        liveFound = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!liveFound && slotOcc[i]) begin
                if (slotLive[i]) begin
                    liveFound = 1'b1;
                end else begin
                    skipCnt = skipCnt + CNT_W'(1);
                end
            end
        end
    end

    assign headIdx    = rdPtrReg + skipCnt[PTR_W-1:0];
    assign inRun      = (stateReg == RUN);
    assign inDrain    = (stateReg == DRAIN);
    assign forceGrant = inRun && liveFound && (starveReg == STARVE_W'(STARVE_MAX));
    assign pipeGrant  = inRun && !forceGrant && pipe_wr_en;
    assign fifoGrant  = liveFound && (inDrain || (inRun && (forceGrant || !pipe_wr_en)));

    assign stall_wb   = rst_n && forceGrant && pipe_wr_en;
    assign late_ready = rst_n && (countReg < CNT_W'(DEPTH)) && (stateReg != HALTED);
    assign fifo_count = countReg;

    // A late beat aimed at the register the pipe is writing now is already stale.
    assign pushFire  = late_valid && late_ready;
    assign pushKeep  = pushFire && !(pipeGrant && (late_reg == pipe_wr_reg));
    assign popCnt    = skipCnt + CNT_W'(fifoGrant);
    assign countNext = countReg + CNT_W'(pushKeep) - popCnt;

    // A stalled halt is re-presented next cycle, so only an unstalled one takes effect.
    assign haltGo    = inRun && pipe_halt && !(forceGrant && pipe_wr_en);
    assign drainDone = inDrain && (countReg == '0) && !late_valid;

    always_comb begin
        liveNext = entryLive;
        if (pipeGrant) begin
            liveNext = liveNext & ~pipeHit;
        end
        if (pushKeep) begin
            liveNext[wrPtrReg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pushKeep) begin
            entryDst[wrPtrReg]  <= late_reg;
            entryData[wrPtrReg] <= late_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg   <= RUN;
            entryLive  <= '0;
            rdPtrReg   <= '0;
            wrPtrReg   <= '0;
            countReg   <= '0;
            starveReg  <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_reg  <= '0;
            rf_wr_data <= '0;
            halt_done  <= 1'b0;
        end else begin
            entryLive <= liveNext;
            rdPtrReg  <= rdPtrReg + popCnt[PTR_W-1:0];
            wrPtrReg  <= wrPtrReg + PTR_W'(pushKeep);
            countReg  <= countNext;

            rf_wr_en <= pipeGrant || fifoGrant;
            if (pipeGrant) begin
                rf_wr_reg  <= pipe_wr_reg;
                rf_wr_data <= pipe_wr_data;
            end else if (fifoGrant) begin
                rf_wr_reg  <= entryDst[headIdx];
                rf_wr_data <= entryData[headIdx];
            end

            if (fifoGrant) begin
                starveReg <= '0;
            end else if (pipeGrant && liveFound && (starveReg != STARVE_W'(STARVE_MAX))) begin
                starveReg <= starveReg + STARVE_W'(1);
            end

            case (stateReg)
                RUN: begin
                    if (haltGo) begin
                        stateReg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drainDone) begin
                        stateReg  <= HALTED;
                        halt_done <= 1'b1;
                    end
                end
                HALTED: begin
                    stateReg <= HALTED;
                end
                default: begin
                    stateReg <= RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scenario bench for wb_port_arbiter: expected register-file writes are queued as
// stimulus is driven and matched in order by a write monitor.
module tb_wb_port_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_wr_en;
    logic [2:0]  pipe_wr_reg;
    logic [15:0] pipe_wr_data;
    logic        pipe_halt;
    logic        late_valid;
    logic [2:0]  late_reg;
    logic [15:0] late_data;
    logic        late_ready;
    logic        stall_wb;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_reg;
    logic [15:0] rf_wr_data;
    logic [1:0]  fifo_count;
    logic        halt_done;

    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] d;
    } wr_t;

    wr_t expQ[$];
    wr_t monExp;
    int  compared   = 0;
    int  mismatched = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wr_en(pipe_wr_en), .pipe_wr_reg(pipe_wr_reg), .pipe_wr_data(pipe_wr_data),
        .pipe_halt(pipe_halt),
        .late_valid(late_valid), .late_reg(late_reg), .late_data(late_data),
        .late_ready(late_ready), .stall_wb(stall_wb),
        .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
        .fifo_count(fifo_count), .halt_done(halt_done)
    );

    // Every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rf_wr_en === 1'b1) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("FAIL rf_write got r%0d=%h expected no write", rf_wr_reg, rf_wr_data);
            end else begin
                monExp = expQ.pop_front();
                if ({rf_wr_reg, rf_wr_data} !== monExp) begin
                    mismatched++;
                    $display("FAIL rf_write got r%0d=%h expected r%0d=%h", rf_wr_reg, rf_wr_data, monExp.r, monExp.d);
                end else begin
                    $display("write r%0d=%h", rf_wr_reg, rf_wr_data);
                end
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic driveIdle();
        pipe_wr_en = 1'b0; pipe_wr_reg = '0; pipe_wr_data = '0; pipe_halt = 1'b0;
        late_valid = 1'b0; late_reg = '0; late_data = '0;
    endtask

    task automatic applyReset();
        nextCycle();
        rst_n = 1'b0;
        driveIdle();
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        nextCycle();
        rst_n = 1'b0;
        driveIdle();
        pipe_wr_en = 1'b1; pipe_wr_reg = 3'd1; late_valid = 1'b1;
        nextCycle();
        nextCycle();
        @(negedge clk);
        compared++; if (rf_wr_en !== 1'b0) begin mismatched++; $display("FAIL reset_rf_wr_en got=%b expected=0", rf_wr_en); end
        compared++; if (rf_wr_reg !== 3'd0) begin mismatched++; $display("FAIL reset_rf_wr_reg got=%0d expected=0", rf_wr_reg); end
        compared++; if (rf_wr_data !== 16'h0) begin mismatched++; $display("FAIL reset_rf_wr_data got=%h expected=0000", rf_wr_data); end
        compared++; if (halt_done !== 1'b0) begin mismatched++; $display("FAIL reset_halt_done got=%b expected=0", halt_done); end
        compared++; if (fifo_count !== 2'd0) begin mismatched++; $display("FAIL reset_fifo_count got=%0d expected=0", fifo_count); end
        compared++; if (stall_wb !== 1'b0) begin mismatched++; $display("FAIL reset_stall_wb got=%b expected=0", stall_wb); end
        compared++; if (late_ready !== 1'b0) begin mismatched++; $display("FAIL reset_late_ready got=%b expected=0", late_ready); end
        nextCycle();
        driveIdle();
        rst_n = 1'b1;
        @(negedge clk);
        compared++; if (late_ready !== 1'b1) begin mismatched++; $display("FAIL post_reset_late_ready got=%b expected=1", late_ready); end
    endtask

    task automatic test_late_basic();
        applyReset();
        nextCycle();
        late_valid = 1'b1; late_reg = 3'd3; late_data = 16'h1234;
        expQ.push_back({3'd3, 16'h1234});
        @(negedge clk);
        compared++; if (late_ready !== 1'b1) begin mismatched++; $display("FAIL basic_late_ready got=%b expected=1", late_ready); end
        nextCycle();
        driveIdle();
        @(negedge clk);
        compared++; if (fifo_count !== 2'd1) begin mismatched++; $display("FAIL basic_fifo_count got=%0d expected=1", fifo_count); end
        compared++; if (rf_wr_en !== 1'b0) begin mismatched++; $display("FAIL basic_early_write got=%b expected=0", rf_wr_en); end
        nextCycle();
        @(negedge clk);
        compared++; if ({rf_wr_en, rf_wr_reg, rf_wr_data} !== {1'b1, 3'd3, 16'h1234}) begin mismatched++; $display("FAIL basic_write got en=%b r%0d=%h expected en=1 r3=1234", rf_wr_en, rf_wr_reg, rf_wr_data); end
        nextCycle();
        @(negedge clk);
        compared++; if (fifo_count !== 2'd0) begin mismatched++; $display("FAIL basic_drained_count got=%0d expected=0", fifo_count); end
        compared++; if (expQ.size() != 0) begin mismatched++; $display("FAIL basic_pending got=%0d expected=0", expQ.size()); expQ.delete(); end
    endtask

    task automatic test_starvation();
        logic [11:0] expReady;
        logic [11:0] expStall;
        int k;
        int j;
        expReady = 12'b1100_0010_0000;
        expStall = 12'b0000_0100_0000;
        k = 0;
        j = 0;
        applyReset();
        expQ.push_back({3'd0, 16'h1000}); expQ.push_back({3'd1, 16'h1001});
        expQ.push_back({3'd0, 16'h1002}); expQ.push_back({3'd1, 16'h1003});
        expQ.push_back({3'd0, 16'h1004}); expQ.push_back({3'd6, 16'hA000});
        expQ.push_back({3'd1, 16'h1005}); expQ.push_back({3'd0, 16'h1006});
        expQ.push_back({3'd7, 16'hA001}); expQ.push_back({3'd6, 16'hA002});
        for (int c = 0; c < 12; c++) begin
            nextCycle();
            pipe_wr_en   = (k < 7);
            pipe_wr_reg  = 3'(k % 2);
            pipe_wr_data = 16'h1000 + 16'(k);
            late_valid   = (j < 3);
            late_reg     = 3'(6 + j % 2);
            late_data    = 16'hA000 + 16'(j);
            @(negedge clk);
            if (c <= 6) begin
                compared++; if (late_ready !== expReady[11-c]) begin mismatched++; $display("FAIL starve_late_ready c%0d got=%b expected=%b", c, late_ready, expReady[11-c]); end
            end
            compared++; if (stall_wb !== expStall[11-c]) begin mismatched++; $display("FAIL starve_stall_wb c%0d got=%b expected=%b", c, stall_wb, expStall[11-c]); end
            if (late_valid && late_ready) j++;
            if (pipe_wr_en && !stall_wb) k++;
        end
        driveIdle();
        compared++; if (expQ.size() != 0) begin mismatched++; $display("FAIL starve_pending got=%0d expected=0", expQ.size()); expQ.delete(); end
    endtask

    task automatic test_supersede();
        applyReset();
        nextCycle();
        late_valid = 1'b1; late_reg = 3'd5; late_data = 16'hAAAA;
        @(negedge clk);
        compared++; if (late_ready !== 1'b1) begin mismatched++; $display("FAIL supersede_ready0 got=%b expected=1", late_ready); end
        nextCycle();
        late_reg = 3'd4; late_data = 16'h4444;
        pipe_wr_en = 1'b1; pipe_wr_reg = 3'd5; pipe_wr_data = 16'h5555;
        expQ.push_back({3'd5, 16'h5555});
        expQ.push_back({3'd4, 16'h4444});
        @(negedge clk);
        compared++; if (late_ready !== 1'b1) begin mismatched++; $display("FAIL supersede_ready1 got=%b expected=1", late_ready); end
        nextCycle();
        driveIdle();
        @(negedge clk);
        compared++; if (fifo_count !== 2'd2) begin mismatched++; $display("FAIL supersede_count_dead got=%0d expected=2", fifo_count); end
        nextCycle();
        nextCycle();
        @(negedge clk);
        compared++; if (fifo_count !== 2'd0) begin mismatched++; $display("FAIL supersede_count_end got=%0d expected=0", fifo_count); end
        nextCycle();
        nextCycle();
        @(negedge clk);
        compared++; if (expQ.size() != 0) begin mismatched++; $display("FAIL supersede_pending got=%0d expected=0", expQ.size()); expQ.delete(); end
    endtask

    task automatic test_same_cycle();
        applyReset();
        nextCycle();
        late_valid = 1'b1; late_reg = 3'd2; late_data = 16'h0001;
        pipe_wr_en = 1'b1; pipe_wr_reg = 3'd2; pipe_wr_data = 16'h0002;
        expQ.push_back({3'd2, 16'h0002});
        @(negedge clk);
        compared++; if (late_ready !== 1'b1) begin mismatched++; $display("FAIL same_late_ready got=%b expected=1", late_ready); end
        nextCycle();
        driveIdle();
        @(negedge clk);
        compared++; if (fifo_count !== 2'd0) begin mismatched++; $display("FAIL same_fifo_count got=%0d expected=0", fifo_count); end
        nextCycle();
        @(negedge clk);
        compared++; if (rf_wr_en !== 1'b0) begin mismatched++; $display("FAIL same_extra_write got=%b expected=0", rf_wr_en); end
        nextCycle();
        @(negedge clk);
        compared++; if (expQ.size() != 0) begin mismatched++; $display("FAIL same_pending got=%0d expected=0", expQ.size()); expQ.delete(); end
    endtask

    task automatic test_halt_drain();
        applyReset();
        nextCycle();
        pipe_wr_en = 1'b1; pipe_wr_reg = 3'd6; pipe_wr_data = 16'h0606;
        late_valid = 1'b1; late_reg = 3'd1; late_data = 16'h0101;
        expQ.push_back({3'd6, 16'h0606});
        nextCycle();
        pipe_wr_reg = 3'd7; pipe_wr_data = 16'h0707;
        late_reg = 3'd2; late_data = 16'h0202;
        expQ.push_back({3'd7, 16'h0707});
        @(negedge clk);
        compared++; if (late_ready !== 1'b1) begin mismatched++; $display("FAIL halt_ready_c1 got=%b expected=1", late_ready); end
        nextCycle();
        pipe_wr_reg = 3'd0; pipe_wr_data = 16'h0F0F; pipe_halt = 1'b1;
        late_reg = 3'd3; late_data = 16'h0303;
        expQ.push_back({3'd0, 16'h0F0F});
        expQ.push_back({3'd1, 16'h0101});
        expQ.push_back({3'd2, 16'h0202});
        expQ.push_back({3'd3, 16'h0303});
        @(negedge clk);
        compared++; if (late_ready !== 1'b0) begin mismatched++; $display("FAIL halt_ready_full got=%b expected=0", late_ready); end
        compared++; if (stall_wb !== 1'b0) begin mismatched++; $display("FAIL halt_stall_c2 got=%b expected=0", stall_wb); end
        nextCycle();
        pipe_halt = 1'b0; pipe_wr_reg = 3'd4; pipe_wr_data = 16'hDEAD;
        @(negedge clk);
        compared++; if (stall_wb !== 1'b0) begin mismatched++; $display("FAIL drain_stall_wb got=%b expected=0", stall_wb); end
        nextCycle();
        @(negedge clk);
        compared++; if (late_ready !== 1'b1) begin mismatched++; $display("FAIL drain_late_ready got=%b expected=1", late_ready); end
        nextCycle();
        late_valid = 1'b0;
        @(negedge clk);
        compared++; if (fifo_count !== 2'd1) begin mismatched++; $display("FAIL drain_count got=%0d expected=1", fifo_count); end
        nextCycle();
        @(negedge clk);
        compared++; if (halt_done !== 1'b0) begin mismatched++; $display("FAIL halt_done_early got=%b expected=0", halt_done); end
        nextCycle();
        @(negedge clk);
        compared++; if (halt_done !== 1'b1) begin mismatched++; $display("FAIL halt_done got=%b expected=1", halt_done); end
        compared++; if (late_ready !== 1'b0) begin mismatched++; $display("FAIL halted_late_ready got=%b expected=0", late_ready); end
        nextCycle();
        late_valid = 1'b1; late_reg = 3'd5; late_data = 16'h5555;
        @(negedge clk);
        compared++; if ({late_ready, fifo_count, halt_done} !== {1'b0, 2'd0, 1'b1}) begin mismatched++; $display("FAIL halted_hold got ready=%b count=%0d done=%b expected ready=0 count=0 done=1", late_ready, fifo_count, halt_done); end
        nextCycle();
        driveIdle();
        @(negedge clk);
        compared++; if (expQ.size() != 0) begin mismatched++; $display("FAIL halt_pending got=%0d expected=0", expQ.size()); expQ.delete(); end
    endtask

    task automatic test_reset_in_drain();
        applyReset();
        nextCycle();
        pipe_wr_en = 1'b1; pipe_wr_reg = 3'd6; pipe_wr_data = 16'h0606;
        late_valid = 1'b1; late_reg = 3'd1; late_data = 16'h1111;
        expQ.push_back({3'd6, 16'h0606});
        nextCycle();
        pipe_wr_reg = 3'd7; pipe_wr_data = 16'h0707; pipe_halt = 1'b1;
        late_valid = 1'b0;
        expQ.push_back({3'd7, 16'h0707});
        @(negedge clk);
        compared++; if (stall_wb !== 1'b0) begin mismatched++; $display("FAIL rstdrain_stall got=%b expected=0", stall_wb); end
        nextCycle();
        driveIdle();
        rst_n = 1'b0;
        @(negedge clk);
        compared++; if (fifo_count !== 2'd1) begin mismatched++; $display("FAIL rstdrain_pre_count got=%0d expected=1", fifo_count); end
        nextCycle();
        rst_n = 1'b1;
        pipe_wr_en = 1'b1; pipe_wr_reg = 3'd3; pipe_wr_data = 16'h0333;
        expQ.push_back({3'd3, 16'h0333});
        @(negedge clk);
        compared++; if ({fifo_count, rf_wr_en, halt_done} !== {2'd0, 1'b0, 1'b0}) begin mismatched++; $display("FAIL rstdrain_flush got count=%0d en=%b done=%b expected count=0 en=0 done=0", fifo_count, rf_wr_en, halt_done); end
        compared++; if (late_ready !== 1'b1) begin mismatched++; $display("FAIL rstdrain_late_ready got=%b expected=1", late_ready); end
        nextCycle();
        driveIdle();
        @(negedge clk);
        compared++; if ({rf_wr_en, rf_wr_reg} !== {1'b1, 3'd3}) begin mismatched++; $display("FAIL rstdrain_run_write got en=%b r%0d expected en=1 r3", rf_wr_en, rf_wr_reg); end
        nextCycle();
        @(negedge clk);
        compared++; if (expQ.size() != 0) begin mismatched++; $display("FAIL rstdrain_pending got=%0d expected=0", expQ.size()); expQ.delete(); end
    endtask

    initial begin
        rst_n = 1'b0;
        driveIdle();
        test_reset();
        test_late_basic();
        test_starvation();
        test_supersede();
        test_same_cycle();
        test_halt_drain();
        test_reset_in_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end
endmodule
